// File: rtl/dstack_pkg.sv
// Shared definitions for the data-stack blocks: movement encodings and index widths.
package dstack_pkg;

    localparam logic [1:0] MOV_HOLD = 2'b00;
    localparam logic [1:0] MOV_PUSH = 2'b01;
    localparam logic [1:0] MOV_POP1 = 2'b10;
    localparam logic [1:0] MOV_POP2 = 2'b11;

    // Occupancy counter holds 0..64, so one bit wider than the entry index.
    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned DEPTH_W = 7;

endpackage

// File: rtl/dstack_guard.sv
// Occupancy counter plus sticky overflow/underflow flags for the data stack.
module dstack_guard
    import dstack_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               halt,
    input  logic [1:0]         movement,
    input  logic               rotate,
    input  logic [ADDR_W-1:0]  rotate_addr,
    input  logic               err_clear,
    output logic [DEPTH_W-1:0] depth,
    output logic               overflow,
    output logic               underflow
);

    localparam logic [DEPTH_W-1:0] DepthLim = DEPTH_W'(DEPTH);

    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q, ovf_d, unf_q, unf_d;
    logic               ovf_set, unf_set;

    always_comb begin
        depth_d = depth_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        unique case (movement)
            MOV_PUSH: begin
                if (depth_q == DepthLim) ovf_set = 1'b1;
                else                     depth_d = depth_q + 1'b1;
            end
            MOV_POP1: begin
                if (depth_q == '0) unf_set = 1'b1;
                else               depth_d = depth_q - 1'b1;
            end
            MOV_POP2: begin
                if (depth_q < DEPTH_W'(2)) begin
                    unf_set = 1'b1;
                    depth_d = '0;
                end else begin
                    depth_d = depth_q - DEPTH_W'(2);
                end
            end
            default: begin
                // Rotating past the valid region reads stale entries.
                if (rotate && (rotate_addr != '0) && ({1'b0, rotate_addr} >= depth_q)) begin
                    unf_set = 1'b1;
                end
            end
        endcase
        if (halt) begin
            depth_d = depth_q;
            ovf_set = 1'b0;
            unf_set = 1'b0;
        end
        ovf_d = err_clear ? 1'b0 : (ovf_q | ovf_set);
        unf_d = err_clear ? 1'b0 : (unf_q | unf_set);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign depth     = depth_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: rtl/dstack_regfile.sv
// Register-based operand stack with push/pop/rotate shifting.
// Depth tracking and error flags are built only when DSTACK_GUARD_EN is defined.
module dstack_regfile
    import dstack_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  halt,
    input  logic [1:0]            movement,
    input  logic [WORD_WIDTH-1:0] next_top,
    input  logic                  rotate,
    input  logic [ADDR_W-1:0]     rotate_addr,
    input  logic                  err_clear,
    output logic [WORD_WIDTH-1:0] top,
    output logic [WORD_WIDTH-1:0] second,
    output logic [WORD_WIDTH-1:0] third,
    output logic [WORD_WIDTH-1:0] rotate_value,
    output logic [DEPTH_W-1:0]    depth,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [DEPTH_W-1:0] DepthLim = DEPTH_W'(DEPTH);

    logic [WORD_WIDTH-1:0] stack_q [DEPTH];
    logic [WORD_WIDTH-1:0] stack_d [DEPTH];
    // Stack extended by two zero words so pops can read past the bottom.
    logic [WORD_WIDTH-1:0] ext     [DEPTH+2];
    logic                  rot_en;

    assign rot_en = (movement == MOV_HOLD) && rotate && (rotate_addr != '0) &&
                    ({1'b0, rotate_addr} < DepthLim);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ext[i] = stack_q[i];
        end
        ext[DEPTH]   = '0;
        ext[DEPTH+1] = '0;
        stack_d      = stack_q;
        stack_d[0]   = next_top;
        for (int i = 1; i < DEPTH; i++) begin
            unique case (movement)
                MOV_PUSH: stack_d[i] = stack_q[i-1];
                MOV_POP1: stack_d[i] = ext[i+1];
                MOV_POP2: stack_d[i] = ext[i+2];
                default: begin
                    if (rot_en && (DEPTH_W'(i) <= {1'b0, rotate_addr})) begin
                        stack_d[i] = stack_q[i-1];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (!halt) begin
            stack_q <= stack_d;
        end
    end

    always_comb begin
        rotate_value = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rotate_addr == ADDR_W'(i)) rotate_value = stack_q[i];
        end
    end

    assign top    = stack_q[0];
    assign second = stack_q[1];
    assign third  = stack_q[2];

`ifdef DSTACK_GUARD_EN
    dstack_guard #(
        .DEPTH(DEPTH)
    ) u_guard (
        .clk        (clk),
        .reset_n    (reset_n),
        .halt       (halt),
        .movement   (movement),
        .rotate     (rotate),
        .rotate_addr(rotate_addr),
        .err_clear  (err_clear),
        .depth      (depth),
        .overflow   (overflow),
        .underflow  (underflow)
    );
`else
    logic unused_err_clear;
    assign unused_err_clear = err_clear;
    assign depth     = '0;
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_dstack_regfile.sv
// Directed table-driven bench for dstack_regfile at DEPTH=4.
module tb_dstack_regfile;

    localparam int unsigned WW = 32;
    localparam int unsigned DP = 4;
    localparam int unsigned NV = 27;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          halt;
    logic [1:0]    movement;
    logic [WW-1:0] next_top;
    logic          rotate;
    logic [5:0]    rotate_addr;
    logic          err_clear;
    logic [WW-1:0] top, second, third, rotate_value;
    logic [6:0]    depth;
    logic          overflow, underflow;

    int n_cmp = 0;
    int n_fail = 0;

    dstack_regfile #(
        .WORD_WIDTH(WW),
        .DEPTH     (DP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .halt        (halt),
        .movement    (movement),
        .next_top    (next_top),
        .rotate      (rotate),
        .rotate_addr (rotate_addr),
        .err_clear   (err_clear),
        .top         (top),
        .second      (second),
        .third       (third),
        .rotate_value(rotate_value),
        .depth       (depth),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          hlt;
        logic [1:0]    mov;
        logic [WW-1:0] nt;
        logic          rot;
        logic [5:0]    ra;
        logic          ec;
        logic [WW-1:0] e_rv;
        logic [WW-1:0] e_top;
        logic [WW-1:0] e_sec;
        logic [WW-1:0] e_thd;
        logic [6:0]    e_dep;
        logic          e_ovf;
        logic          e_unf;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic hlt, input logic [1:0] mov, input logic [WW-1:0] nt,
                                input logic rot, input logic [5:0] ra, input logic ec,
                                input logic [WW-1:0] e_rv, input logic [WW-1:0] e_top,
                                input logic [WW-1:0] e_sec, input logic [WW-1:0] e_thd,
                                input logic [6:0] e_dep, input logic e_ovf, input logic e_unf);
        vec_t v;
        v.hlt = hlt; v.mov = mov; v.nt = nt; v.rot = rot; v.ra = ra; v.ec = ec;
        v.e_rv = e_rv; v.e_top = e_top; v.e_sec = e_sec; v.e_thd = e_thd;
`ifdef DSTACK_GUARD_EN
        v.e_dep = e_dep; v.e_ovf = e_ovf; v.e_unf = e_unf;
`else
        v.e_dep = 7'd0; v.e_ovf = 1'b0; v.e_unf = 1'b0;
        if (e_dep == 7'd127 && e_ovf && e_unf) v.e_dep = 7'd0;
`endif
        return v;
    endfunction

    function automatic logic [6:0] gdep(input logic [6:0] d);
`ifdef DSTACK_GUARD_EN
        return d;
`else
        if (d == 7'd127) return 7'd0;
        return 7'd0;
`endif
    endfunction

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [WW-1:0] t, input logic [WW-1:0] s,
                              input logic [WW-1:0] th, input logic [6:0] d, input logic o,
                              input logic u);
        check({tag, " top"}, top, t);
        check({tag, " second"}, second, s);
        check({tag, " third"}, third, th);
        check({tag, " depth"}, WW'(depth), WW'(d));
        check({tag, " overflow"}, WW'(overflow), WW'(o));
        check({tag, " underflow"}, WW'(underflow), WW'(u));
    endtask

    task automatic drive(input logic h, input logic [1:0] m, input logic [WW-1:0] nt,
                         input logic r, input logic [5:0] a, input logic ec);
        halt = h; movement = m; next_top = nt; rotate = r; rotate_addr = a; err_clear = ec;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 2'b00, '0, 1'b0, 6'd0, 1'b0);

        // hlt mov  nt      rot ra ec   rv      top     sec     thd     dep ovf unf
        vecs[0]  = mk(0, 2'b01, 32'h11, 0, 0, 0, 32'h00, 32'h11, 32'h00, 32'h00, 1, 0, 0);
        vecs[1]  = mk(0, 2'b01, 32'h22, 0, 0, 0, 32'h11, 32'h22, 32'h11, 32'h00, 2, 0, 0);
        vecs[2]  = mk(0, 2'b01, 32'h33, 0, 0, 0, 32'h22, 32'h33, 32'h22, 32'h11, 3, 0, 0);
        vecs[3]  = mk(0, 2'b10, 32'h55, 0, 0, 0, 32'h33, 32'h55, 32'h11, 32'h00, 2, 0, 0);
        vecs[4]  = mk(0, 2'b11, 32'h00, 0, 0, 0, 32'h55, 32'h00, 32'h00, 32'h00, 0, 0, 0);
        vecs[5]  = mk(0, 2'b01, 32'hDD, 0, 0, 0, 32'h00, 32'hDD, 32'h00, 32'h00, 1, 0, 0);
        vecs[6]  = mk(0, 2'b01, 32'hCC, 0, 0, 0, 32'hDD, 32'hCC, 32'hDD, 32'h00, 2, 0, 0);
        vecs[7]  = mk(0, 2'b01, 32'hBB, 0, 0, 0, 32'hCC, 32'hBB, 32'hCC, 32'hDD, 3, 0, 0);
        vecs[8]  = mk(0, 2'b01, 32'hAA, 0, 0, 0, 32'hBB, 32'hAA, 32'hBB, 32'hCC, 4, 0, 0);
        vecs[9]  = mk(0, 2'b00, 32'hDD, 1, 3, 0, 32'hDD, 32'hDD, 32'hAA, 32'hBB, 4, 0, 0);
        vecs[10] = mk(0, 2'b00, 32'hDD, 0, 3, 0, 32'hCC, 32'hDD, 32'hAA, 32'hBB, 4, 0, 0);
        vecs[11] = mk(0, 2'b01, 32'hEE, 0, 3, 0, 32'hCC, 32'hEE, 32'hDD, 32'hAA, 4, 1, 0);
        vecs[12] = mk(0, 2'b00, 32'hEE, 0, 3, 1, 32'hBB, 32'hEE, 32'hDD, 32'hAA, 4, 0, 0);
        vecs[13] = mk(0, 2'b10, 32'hEE, 0, 0, 0, 32'hEE, 32'hEE, 32'hAA, 32'hBB, 3, 0, 0);
        vecs[14] = mk(0, 2'b01, 32'hBB, 0, 2, 0, 32'hBB, 32'hBB, 32'hEE, 32'hAA, 4, 0, 0);
        vecs[15] = mk(0, 2'b00, 32'hBB, 0, 3, 0, 32'hBB, 32'hBB, 32'hEE, 32'hAA, 4, 0, 0);
        vecs[16] = mk(0, 2'b00, 32'hBB, 1, 5, 0, 32'h00, 32'hBB, 32'hEE, 32'hAA, 4, 0, 1);
        vecs[17] = mk(0, 2'b00, 32'hBB, 0, 0, 1, 32'hBB, 32'hBB, 32'hEE, 32'hAA, 4, 0, 0);
        vecs[18] = mk(0, 2'b11, 32'h11, 0, 0, 0, 32'hBB, 32'h11, 32'hBB, 32'h00, 2, 0, 0);
        vecs[19] = mk(0, 2'b10, 32'h22, 0, 0, 0, 32'h11, 32'h22, 32'h00, 32'h00, 1, 0, 0);
        vecs[20] = mk(0, 2'b11, 32'h33, 0, 0, 0, 32'h22, 32'h33, 32'h00, 32'h00, 0, 0, 1);
        vecs[21] = mk(0, 2'b10, 32'h44, 0, 0, 1, 32'h33, 32'h44, 32'h00, 32'h00, 0, 0, 0);
        vecs[22] = mk(0, 2'b00, 32'h00, 1, 2, 0, 32'h00, 32'h00, 32'h44, 32'h00, 0, 0, 1);
        vecs[23] = mk(1, 2'b01, 32'h99, 0, 0, 0, 32'h00, 32'h00, 32'h44, 32'h00, 0, 0, 1);
        vecs[24] = mk(1, 2'b00, 32'h99, 0, 0, 1, 32'h00, 32'h00, 32'h44, 32'h00, 0, 0, 0);
        vecs[25] = mk(0, 2'b01, 32'h55, 1, 2, 0, 32'h00, 32'h55, 32'h00, 32'h44, 1, 0, 0);
        vecs[26] = mk(0, 2'b00, 32'h66, 1, 0, 0, 32'h55, 32'h66, 32'h00, 32'h44, 1, 0, 0);

        #1;
        check_regs("reset", '0, '0, '0, 7'd0, 1'b0, 1'b0);
        check("reset rotate_value", rotate_value, '0);

        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].hlt, vecs[i].mov, vecs[i].nt, vecs[i].rot, vecs[i].ra, vecs[i].ec);
            #1;
            check($sformatf("v%0d rotate_value", i), rotate_value, vecs[i].e_rv);
            @(posedge clk);
            #1;
            check_regs($sformatf("v%0d", i), vecs[i].e_top, vecs[i].e_sec, vecs[i].e_thd,
                       vecs[i].e_dep, vecs[i].e_ovf, vecs[i].e_unf);
            @(negedge clk);
        end

        // Halt pulse in the middle of a push stream: state 66,00,44 depth 1.
        drive(1'b0, 2'b01, 32'hA1, 1'b0, 6'd0, 1'b0);
        @(posedge clk); #1;
        check_regs("push A1", 32'hA1, 32'h66, 32'h00, gdep(7'd2), 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 2'b01, 32'hA2, 1'b0, 6'd0, 1'b0);
        @(posedge clk); #1;
        check_regs("halted push", 32'hA1, 32'h66, 32'h00, gdep(7'd2), 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 2'b01, 32'hA3, 1'b0, 6'd1, 1'b0);
        @(posedge clk); #1;
        check_regs("push A3", 32'hA3, 32'hA1, 32'h66, gdep(7'd3), 1'b0, 1'b0);

        // Asynchronous reset between edges clears everything without a clock.
        @(negedge clk);
        drive(1'b0, 2'b01, 32'hB1, 1'b0, 6'd1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_regs("async reset", '0, '0, '0, 7'd0, 1'b0, 1'b0);
        check("async reset rotate_value", rotate_value, '0);
        @(posedge clk); #1;
        check_regs("held in reset", '0, '0, '0, 7'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 2'b01, 32'h77, 1'b0, 6'd0, 1'b0);
        @(posedge clk); #1;
        check_regs("first after reset", 32'h77, '0, '0, gdep(7'd1), 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
